fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single FIFO write interface among NUM_USERS user requesters in the server/user processing system. It grants one user at a time and drives `wr_en`/`data_in` into the FIFO. For each write it waits for the FIFO's `wr_ack` or `overflow` before the next write. Each write result goes back to the granted user as a done/error pulse; the pointer rotates after each grant so no user is starved.

## Interface
- FIFO_WIDTH, 16, data width of each user word and of FIFO `data_in`
- NUM_USERS, 4, number of requesters (2..8)
- MAX_BURST, 4, max consecutive writes one user may make per grant (1..15)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- usr_req  in  NUM_USERS  per-user write request; level, held until usr_done/usr_err
- usr_data  in  NUM_USERS*FIFO_WIDTH  packed user words, user i at [i*FIFO_WIDTH +: FIFO_WIDTH]
- usr_gnt  out  NUM_USERS  one-hot; high from WRITE through WAIT_ACK for the granted user
- usr_done  out  NUM_USERS  one-cycle pulse: the user's word was acknowledged by the FIFO
- usr_err  out  NUM_USERS  one-cycle pulse: write overflowed or was not acknowledged
- fifo_wr_en  out  1  FIFO write enable
- fifo_data_in  out  FIFO_WIDTH  FIFO write data
- fifo_full  in  1  FIFO full flag
- fifo_wr_ack  in  1  FIFO write acknowledge (registered in FIFO)
- fifo_overflow  in  1  FIFO overflow flag (registered in FIFO)
- busy  out  1  high whenever the state is not IDLE
- grant_id  out  $clog2(NUM_USERS)  index of the current or last granted user

## Operation
- FSM states: IDLE, WRITE, WAIT_ACK.
- **IDLE**
  - If any usr_req bit is high and fifo_full=0, the arbiter picks the first requester at or after rr_ptr, wrapping modulo NUM_USERS.
  - It registers grant_id and sets burst_cnt=1.
  - Next state: WRITE.
- **WRITE**
  - fifo_wr_en=1 and fifo_data_in=usr_data[grant_id] for exactly one cycle.
  - Next state: WAIT_ACK.
- **WAIT_ACK**
  - fifo_wr_en=0. The arbiter samples fifo_wr_ack and fifo_overflow.
  - wr_ack=1 gives a usr_done pulse. overflow=1, or neither flag high, gives a usr_err pulse.
  - Both pulses are registered and appear in the cycle after WAIT_ACK.
- **After WAIT_ACK**
  - The burst continues (next state WRITE, burst_cnt+1) only if all of the following hold: usr_req[grant_id]=1, burst_cnt<MAX_BURST, fifo_full=0, and the current write was not an error.
  - Otherwise the next state is IDLE and rr_ptr = (grant_id+1) mod NUM_USERS.
- A user sees usr_done and may then present new data or drop its request. During a continued burst, the data presented on the WRITE cycle is the data written.
- fifo_full=1 in IDLE blocks all grants; requests stay pending.
- A user that drops usr_req mid-write still gets its done/err pulse.
- Reset mid-operation clears everything immediately: fifo_wr_en falls asynchronously and no done/err pulse is generated.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0, burst_cnt=0, grant_id=0.
  - usr_gnt, usr_done and usr_err are all 0.
  - fifo_wr_en=0, fifo_data_in=0, busy=0.
- Latency: usr_req rising in IDLE (FIFO not full) at edge N gives fifo_wr_en high in cycle N+1, done/err in cycle N+3.
- Throughput: one write per 2 cycles inside a burst; burst end to the next grant costs 1 extra IDLE cycle.
- With simultaneous requests, a user is served in round-robin order from rr_ptr; rr_ptr wraps NUM_USERS-1 to 0.

## Configuration
- Macro: FIFO_WR_ARBITER_STATS_EN.
- With the macro defined, the block adds these outputs:
  - wr_count: NUM_USERS×16 bits, per-user acknowledged-write counters.
  - err_count: NUM_USERS×16 bits, per-user error counters.
  - Both counters saturate at 16'hFFFF and are cleared by rst.
- Without the macro, these ports and counters are absent and behaviour is otherwise identical.

## Structure
- Shared package fifo_arb_pkg holds:
  - typedef enum arb_state_e {IDLE, WRITE, WAIT_ACK}.
  - Default constants for NUM_USERS, MAX_BURST and the stats counter width (16).
- One sub-module, rr_picker: combinational round-robin select (inputs req vector and rr_ptr; outputs valid and index). It is instantiated once.

## Test plan
- Reset then single request: usr_req=4'b0010, data 16'hA5A5, FIFO empty → fifo_wr_en high one cycle with 16'hA5A5, usr_done[1] pulse 2 cycles later, grant_id=1, rr_ptr=2.
- All four users request continuously, MAX_BURST=1 → grant order 0,1,2,3,0, and each grant yields exactly one write.
- Burst cap: user 2 requests continuously with MAX_BURST=4 and user 3 also requesting → four user-2 writes, then user 3 is granted.
- Full blocking: fifo_full=1 with usr_req=4'b1111 for 10 cycles → fifo_wr_en stays 0 and busy=0. Release full → a grant follows 1 cycle later.
- Overflow response: force fifo_overflow=1, wr_ack=0 in WAIT_ACK → usr_err pulse for the granted user, the burst terminates, and state returns to IDLE.
- Reset asserted during WRITE → fifo_wr_en drops without waiting for a clock edge, no done pulse, all outputs at reset values. With FIFO_WR_ARBITER_STATS_EN, the counters read 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default constants for the FIFO write-port arbiter.
// Holds the arbiter state encoding and the sizing defaults used by the top, the interface and the picker.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        WAIT_ACK = 2'd2
    } arb_state_e;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_NUM_USERS  = 4;
    localparam int DEF_MAX_BURST  = 4;
    localparam int STATS_W        = 16;
    // MAX_BURST is limited to 15, so a 4-bit burst counter always suffices.
    localparam int BURST_W        = 4;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// User-side and FIFO-side write bus of the arbiter.
// The master modport is the arbiter; the slave modport is the users plus the FIFO.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int NUM_USERS  = DEF_NUM_USERS
);

    logic [NUM_USERS-1:0]            usr_req;
    logic [NUM_USERS*FIFO_WIDTH-1:0] usr_data;
    logic [NUM_USERS-1:0]            usr_gnt;
    logic [NUM_USERS-1:0]            usr_done;
    logic [NUM_USERS-1:0]            usr_err;
    logic                            fifo_wr_en;
    logic [FIFO_WIDTH-1:0]           fifo_data_in;
    logic                            fifo_full;
    logic                            fifo_wr_ack;
    logic                            fifo_overflow;

    modport master (
        input  usr_req,
        input  usr_data,
        output usr_gnt,
        output usr_done,
        output usr_err,
        output fifo_wr_en,
        output fifo_data_in,
        input  fifo_full,
        input  fifo_wr_ack,
        input  fifo_overflow
    );

    modport slave (
        output usr_req,
        output usr_data,
        input  usr_gnt,
        input  usr_done,
        input  usr_err,
        input  fifo_wr_en,
        input  fifo_data_in,
        output fifo_full,
        output fifo_wr_ack,
        output fifo_overflow
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin selector: first requester at or after rr_ptr, wrapping modulo NUM_USERS.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_USERS = DEF_NUM_USERS,
    localparam int IDX_W     = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1
) (
    input  logic [NUM_USERS-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic                 valid,
    output logic [IDX_W-1:0]     index
);

    logic [IDX_W-1:0] cand;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= NUM_USERS) s = s - NUM_USERS;
        return IDX_W'(s);
    endfunction

    // Scan from the farthest offset down so the nearest requester is the last one written.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int i = NUM_USERS - 1; i >= 0; i--) begin
            cand = wrap_add(rr_ptr, i);
            if (req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_USERS requesters, with bounded bursts.
// Optional per-user write/error counters are built when FIFO_WR_ARBITER_STATS_EN is defined.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter  int NUM_USERS  = DEF_NUM_USERS,
    parameter  int MAX_BURST  = DEF_MAX_BURST,
    localparam int IDX_W      = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    fifo_wr_arbiter_if.master            bus,
    output logic                         busy,
    output logic [IDX_W-1:0]             grant_id
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    output logic [NUM_USERS*STATS_W-1:0] wr_count,
    output logic [NUM_USERS*STATS_W-1:0] err_count
`endif
);

    arb_state_e           state, state_nxt;
    logic [IDX_W-1:0]     rr_ptr, rr_ptr_nxt, grant_id_nxt;
    logic [BURST_W-1:0]   burst_cnt, burst_cnt_nxt;
    logic [NUM_USERS-1:0] done_q, err_q, done_nxt, err_nxt;
    logic [NUM_USERS-1:0] gnt;
    logic                 pick_vld;
    logic [IDX_W-1:0]     pick_idx;
    logic                 wr_err;
    logic                 burst_more;
    logic [FIFO_WIDTH-1:0] usr_word [NUM_USERS];

    for (genvar g = 0; g < NUM_USERS; g++) begin : g_word
        assign usr_word[g] = bus.usr_data[g*FIFO_WIDTH +: FIFO_WIDTH];
    end

    rr_picker #(
        .NUM_USERS (NUM_USERS)
    ) u_picker (
        .req    (bus.usr_req),
        .rr_ptr (rr_ptr),
        .valid  (pick_vld),
        .index  (pick_idx)
    );

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] id);
        return (id == IDX_W'(NUM_USERS - 1)) ? '0 : id + 1'b1;
    endfunction

    // A write without acknowledge counts as an error, as does an overflow even if acked.
    assign wr_err     = bus.fifo_overflow | ~bus.fifo_wr_ack;
    assign burst_more = bus.usr_req[grant_id] & (burst_cnt < BURST_W'(MAX_BURST)) &
                        ~bus.fifo_full & ~wr_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        grant_id_nxt  = grant_id;
        burst_cnt_nxt = burst_cnt;
        done_nxt      = '0;
        err_nxt       = '0;
        case (state)
            IDLE: begin
                if (pick_vld && !bus.fifo_full) begin
                    grant_id_nxt  = pick_idx;
                    burst_cnt_nxt = BURST_W'(1);
                    state_nxt     = WRITE;
                end
            end
            WRITE: state_nxt = WAIT_ACK;
            WAIT_ACK: begin
                if (wr_err) err_nxt[grant_id]  = 1'b1;
                else        done_nxt[grant_id] = 1'b1;
                if (burst_more) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                    state_nxt     = WRITE;
                end else begin
                    rr_ptr_nxt = next_ptr(grant_id);
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            grant_id  <= '0;
            burst_cnt <= '0;
            done_q    <= '0;
            err_q     <= '0;
        end else begin
            rr_ptr    <= rr_ptr_nxt;
            grant_id  <= grant_id_nxt;
            burst_cnt <= burst_cnt_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
        end
    end

    // Write strobe and data decode straight from state so reset removes them without a clock.
    always_comb begin
        gnt = '0;
        if (state != IDLE) gnt[grant_id] = 1'b1;
    end

    assign busy             = (state != IDLE);
    assign bus.fifo_wr_en   = (state == WRITE);
    assign bus.fifo_data_in = (state == WRITE) ? usr_word[grant_id] : '0;
    assign bus.usr_gnt      = gnt;
    assign bus.usr_done     = done_q;
    assign bus.usr_err      = err_q;

`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [STATS_W-1:0] wr_cnt_q  [NUM_USERS];
    logic [STATS_W-1:0] err_cnt_q [NUM_USERS];

    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_USERS; i++) begin
                wr_cnt_q[i]  <= '0;
                err_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_USERS; i++) begin
                if (done_nxt[i]) wr_cnt_q[i]  <= sat_inc(wr_cnt_q[i]);
                if (err_nxt[i])  err_cnt_q[i] <= sat_inc(err_cnt_q[i]);
            end
        end
    end

    for (genvar g = 0; g < NUM_USERS; g++) begin : g_stats
        assign wr_count[g*STATS_W +: STATS_W]  = wr_cnt_q[g];
        assign err_count[g*STATS_W +: STATS_W] = err_cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: one instance with MAX_BURST=4, one with MAX_BURST=1,
// each driven by a small registered-ack FIFO model.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int a_mode  = 0;   // 0 ack, 1 overflow, 2 no response

    always @(posedge clk) cyc <= cyc + 1;

    fifo_wr_arbiter_if #(.FIFO_WIDTH(W), .NUM_USERS(N)) a_if ();
    fifo_wr_arbiter_if #(.FIFO_WIDTH(W), .NUM_USERS(N)) b_if ();

    logic          a_busy, b_busy;
    logic [IW-1:0] a_gid, b_gid;
`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [N*16-1:0] a_wrc, a_errc, b_wrc, b_errc;
`endif

    fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_USERS(N), .MAX_BURST(4)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .bus      (a_if.master),
        .busy     (a_busy),
        .grant_id (a_gid)
`ifdef FIFO_WR_ARBITER_STATS_EN
        ,
        .wr_count (a_wrc),
        .err_count(a_errc)
`endif
    );

    fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_USERS(N), .MAX_BURST(1)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .bus      (b_if.master),
        .busy     (b_busy),
        .grant_id (b_gid)
`ifdef FIFO_WR_ARBITER_STATS_EN
        ,
        .wr_count (b_wrc),
        .err_count(b_errc)
`endif
    );

    // FIFO models: response flags registered one cycle after the write strobe.
    always @(posedge clk) begin : a_fifo
        logic w;
        w = a_if.fifo_wr_en;
        #1;
        a_if.fifo_wr_ack   = w && (a_mode == 0);
        a_if.fifo_overflow = w && (a_mode == 1);
    end

    always @(posedge clk) begin : b_fifo
        logic w;
        w = b_if.fifo_wr_en;
        #1;
        b_if.fifo_wr_ack   = w;
        b_if.fifo_overflow = 1'b0;
    end

    int a_log_gid[$], a_log_dat[$], a_log_cyc[$];
    int b_log_gid[$], b_log_dat[$], b_log_cyc[$];

    always @(negedge clk) begin
        if (a_if.fifo_wr_en) begin
            a_log_gid.push_back(int'(a_gid));
            a_log_dat.push_back(int'(a_if.fifo_data_in));
            a_log_cyc.push_back(cyc);
        end
        if (b_if.fifo_wr_en) begin
            b_log_gid.push_back(int'(b_gid));
            b_log_dat.push_back(int'(b_if.fifo_data_in));
            b_log_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_if.usr_req = '0; a_if.usr_data = '0; a_if.fifo_full = 1'b0;
        a_if.fifo_wr_ack = 1'b0; a_if.fifo_overflow = 1'b0;
        b_if.usr_req = '0; b_if.usr_data = '0; b_if.fifo_full = 1'b0;
        b_if.fifo_wr_ack = 1'b0; b_if.fifo_overflow = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_wr_en",   32'(a_if.fifo_wr_en),   0);
        check_eq("rst_data_in", 32'(a_if.fifo_data_in), 0);
        check_eq("rst_busy",    32'(a_busy),            0);
        check_eq("rst_gid",     32'(a_gid),             0);
        check_eq("rst_gnt",     32'(a_if.usr_gnt),      0);
        check_eq("rst_done",    32'(a_if.usr_done),     0);
        check_eq("rst_err",     32'(a_if.usr_err),      0);
        check_eq("rst_rr_ptr",  32'(dut_a.rr_ptr),      0);
        step();
        rst = 1'b0;

        // Single request from user 1, dropped during its write
        a_if.usr_data[1*W +: W] = 16'hA5A5;
        a_if.usr_req = 4'b0010;
        step();
        a_if.usr_req = 4'b0000;
        @(negedge clk);
        check_eq("t1_wr_en",  32'(a_if.fifo_wr_en),   1);
        check_eq("t1_data",   32'(a_if.fifo_data_in), 'hA5A5);
        check_eq("t1_gnt",    32'(a_if.usr_gnt),      'b0010);
        check_eq("t1_gid",    32'(a_gid),             1);
        check_eq("t1_busy",   32'(a_busy),            1);
        @(negedge clk);
        check_eq("t1_wr_en_low", 32'(a_if.fifo_wr_en), 0);
        check_eq("t1_done_early", 32'(a_if.usr_done), 0);
        @(negedge clk);
        check_eq("t1_done",   32'(a_if.usr_done), 'b0010);
        check_eq("t1_err",    32'(a_if.usr_err),  0);
        check_eq("t1_idle",   32'(a_busy),        0);
        check_eq("t1_gid2",   32'(a_gid),         1);
        check_eq("t1_rr_ptr", 32'(dut_a.rr_ptr),  2);
        @(negedge clk);
        check_eq("t1_done_once", 32'(a_if.usr_done), 0);
        check_eq("t1_nwrites", 32'(a_log_gid.size()), 1);
`ifdef FIFO_WR_ARBITER_STATS_EN
        check_eq("t1_wr_count1", 32'(a_wrc[1*16 +: 16]), 1);
`endif

        // All four users on the MAX_BURST=1 instance: strict rotation
        for (int i = 0; i < N; i++) b_if.usr_data[i*W +: W] = 16'(16'h1000 + i);
        step();
        b_if.usr_req = 4'b1111;
        repeat (14) step();
        b_if.usr_req = 4'b0000;
        repeat (6) step();
        check_eq("t2_nwrites", 32'(b_log_gid.size()), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < b_log_gid.size()) begin
                check_eq("t2_order", 32'(b_log_gid[i]), 32'(i % N));
                check_eq("t2_data",  32'(b_log_dat[i]), 32'('h1000 + (i % N)));
            end
        end
        if (b_log_cyc.size() >= 2)
            check_eq("t2_spacing", 32'(b_log_cyc[1] - b_log_cyc[0]), 3);
        check_eq("t2_rr_ptr", 32'(dut_b.rr_ptr), 1);

        // Burst cap: user 2 capped at four writes, then user 3
        a_log_gid.delete(); a_log_dat.delete(); a_log_cyc.delete();
        a_if.usr_data[2*W +: W] = 16'h2222;
        a_if.usr_data[3*W +: W] = 16'h3333;
        a_if.usr_req = 4'b1100;
        repeat (12) step();
        a_if.usr_req = 4'b0000;
        repeat (12) step();
        check_eq("t3_nwrites", 32'(a_log_gid.size()), 6);
        if (a_log_gid.size() >= 6) begin
            for (int i = 0; i < 4; i++) begin
                check_eq("t3_u2_gid",  32'(a_log_gid[i]), 2);
                check_eq("t3_u2_data", 32'(a_log_dat[i]), 'h2222);
            end
            check_eq("t3_u3_gid",  32'(a_log_gid[4]), 3);
            check_eq("t3_u3_data", 32'(a_log_dat[4]), 'h3333);
            check_eq("t3_burst_gap", 32'(a_log_cyc[1] - a_log_cyc[0]), 2);
            check_eq("t3_switch_gap", 32'(a_log_cyc[4] - a_log_cyc[3]), 3);
        end
        check_eq("t3_rr_wrap", 32'(dut_a.rr_ptr), 0);

        // Full FIFO blocks every grant
        a_if.fifo_full = 1'b1;
        a_if.usr_req = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("t4_full_wr_en", 32'(a_if.fifo_wr_en), 0);
            check_eq("t4_full_busy",  32'(a_busy),          0);
        end
        step();
        a_if.fifo_full = 1'b0;
        @(negedge clk);
        check_eq("t4_release_wait", 32'(a_if.fifo_wr_en), 0);
        step();
        a_if.usr_req = 4'b0000;
        @(negedge clk);
        check_eq("t4_grant_wr_en", 32'(a_if.fifo_wr_en), 1);
        check_eq("t4_grant_gid",   32'(a_gid),           0);
        repeat (4) step();

        // Overflow ends the burst with an error pulse
        a_mode = 1;
        a_if.usr_data[1*W +: W] = 16'h5A5A;
        a_if.usr_req = 4'b0010;
        step();
        step();
        @(negedge clk);
        check_eq("t5_wait_busy", 32'(a_busy), 1);
        step();
        check_eq("t5_err",     32'(a_if.usr_err),  'b0010);
        check_eq("t5_no_done", 32'(a_if.usr_done), 0);
        check_eq("t5_idle",    32'(a_busy),        0);
        check_eq("t5_gnt",     32'(a_if.usr_gnt),  0);
        check_eq("t5_rr_ptr",  32'(dut_a.rr_ptr),  2);
        a_if.usr_req = 4'b0000;
`ifdef FIFO_WR_ARBITER_STATS_EN
        check_eq("t5_err_count1", 32'(a_errc[1*16 +: 16]), 1);
`endif
        step();
        check_eq("t5_err_once", 32'(a_if.usr_err), 0);

        // Missing acknowledge is also an error
        a_mode = 2;
        a_if.usr_req = 4'b1000;
        step();
        step();
        step();
        check_eq("t5b_err",     32'(a_if.usr_err),  'b1000);
        check_eq("t5b_no_done", 32'(a_if.usr_done), 0);
        check_eq("t5b_idle",    32'(a_busy),        0);
        a_if.usr_req = 4'b0000;
        step();
        a_mode = 0;
        step();

        // Reset during a write
        a_if.usr_data[0*W +: W] = 16'h0F0F;
        a_if.usr_req = 4'b0001;
        step();
        check_eq("t6_in_write", 32'(a_if.fifo_wr_en), 1);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_async_wr_en", 32'(a_if.fifo_wr_en),   0);
        check_eq("t6_async_data",  32'(a_if.fifo_data_in), 0);
        check_eq("t6_async_busy",  32'(a_busy),            0);
        check_eq("t6_async_gnt",   32'(a_if.usr_gnt),      0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t6_rst_done", 32'(a_if.usr_done), 0);
            check_eq("t6_rst_err",  32'(a_if.usr_err),  0);
            check_eq("t6_rst_gid",  32'(a_gid),         0);
        end
        check_eq("t6_rst_rr_ptr", 32'(dut_a.rr_ptr), 0);
`ifdef FIFO_WR_ARBITER_STATS_EN
        check_eq("t6_wr_count_clr",  32'(a_wrc[1*16 +: 16]),  0);
        check_eq("t6_err_count_clr", 32'(a_errc[1*16 +: 16]), 0);
`endif
        a_if.usr_req = 4'b0000;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t6_post_done", 32'(a_if.usr_done), 0);
            check_eq("t6_post_busy", 32'(a_busy),        0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
